n101_uartrx_fifo: RTL

Receive-side byte FIFO placed directly downstream of the UART receiver in the peripheral subsystem. It captures each valid/bits pulse from the receiver and buffers the bytes for the bus register interface, which pops them through a ready/valid dequeue port. It also provides a fill count, a watermark interrupt-pending flag and a sticky overflow flag, because the receiver has no backpressure.

---
 rtl/n101_uartrx_fifo_if.sv | 29 ++
 rtl/n101_uartrx_fifo.sv | 97 +++++++++
 2 files changed

// File: rtl/n101_uartrx_fifo_if.sv
// Bus-side bundle for the UART receive FIFO: enqueue pulse from the receiver,
// ready/valid dequeue port, watermark, flush and overflow status.
interface n101_uartrx_fifo_if #(
  parameter int AW = 3
);
  logic          io_enq_valid;
  logic [7:0]    io_enq_bits;
  logic          io_deq_ready;
  logic          io_deq_valid;
  logic [7:0]    io_deq_bits;
  logic [AW:0]   io_count;
  logic [AW-1:0] io_rxcnt;
  logic          io_ip;
  logic          io_flush;
  logic          io_ovf;
  logic          io_ovf_clr;

  // Receiver/consumer side: drives requests, observes FIFO status
  modport master (
    output io_enq_valid, io_enq_bits, io_deq_ready, io_rxcnt, io_flush, io_ovf_clr,
    input  io_deq_valid, io_deq_bits, io_count, io_ip, io_ovf
  );

  // FIFO side
  modport slave (
    input  io_enq_valid, io_enq_bits, io_deq_ready, io_rxcnt, io_flush, io_ovf_clr,
    output io_deq_valid, io_deq_bits, io_count, io_ip, io_ovf
  );
endinterface

// File: rtl/n101_uartrx_fifo.sv
// Receive byte FIFO behind the UART receiver. The receiver cannot be stalled,
// so a byte arriving while full (with no pop) is dropped and flagged in a
// sticky overflow bit. Head data is read combinationally from registered state.
module n101_uartrx_fifo #(
  parameter int AW = 3
) (
  input  logic            clock,
  input  logic            reset,
  n101_uartrx_fifo_if.slave bus
);
  localparam int          DEPTH  = 1 << AW;
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] PINC_C = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic empty_s, full_s, enq_s, deq_s, ovf_evt_s;

  // Per-cycle enqueue/dequeue/overflow events
  always_comb begin
    empty_s   = (count_q == '0);
    full_s    = (count_q == FULL_C);
    deq_s     = bus.io_deq_ready & ~empty_s;
    enq_s     = bus.io_enq_valid & (~full_s | deq_s);
    // A flushed cycle discards its byte without counting it as an overflow
    ovf_evt_s = bus.io_enq_valid & full_s & ~deq_s & ~bus.io_flush;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.io_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq_s) begin
        wptr_d = wptr_q + PINC_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (deq_s) begin
        rptr_d = rptr_q + PINC_C;
      end else begin
        rptr_d = rptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
    // Set wins over clear so a same-cycle overflow is never lost
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (bus.io_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (enq_s && !bus.io_flush) begin
      mem_q[wptr_q] <= bus.io_enq_bits;
    end
  end

  assign bus.io_deq_valid = ~empty_s;
  assign bus.io_deq_bits  = empty_s ? 8'h00 : mem_q[rptr_q];
  assign bus.io_count     = count_q;
  assign bus.io_ip        = (count_q > {1'b0, bus.io_rxcnt});
  assign bus.io_ovf       = ovf_q;
endmodule
